des_perm_stream: RTL and testbench



---
 rtl/des_perm_stream.sv | 111 +++++++++++
 tb/tb_des_perm_stream.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_perm_stream.sv
// Multi-lane DES IP / IP^-1 / pass-through permutation unit with a PIPE-deep
// registered, back-pressurable valid/ready pipeline and an accepted-beat counter.
module des_perm_stream #(
    parameter int unsigned LANES = 1,
    parameter int unsigned PIPE  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_mode,
    input  logic [64*LANES-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [64*LANES-1:0]   out_data,
    output logic [31:0]           beat_count,
    output logic                  mode_err,
    input  logic                  err_clr
);

    localparam int unsigned W = 64 * LANES;

    localparam logic [1:0] MODE_IP     = 2'b01;
    localparam logic [1:0] MODE_IP_INV = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    logic [W-1:0]    data_q [PIPE];
    logic [PIPE-1:0] v_q;
    logic [PIPE-1:0] rdy;
    logic            rdy_acc;
    logic [W-1:0]    perm_beat;
    logic [31:0]     count_q;
    logic            mode_err_q;
    logic            accept;

    // DES bit i is lane bit 64-i; src is the DES index of the input bit feeding output bit i.
    function automatic logic [63:0] perm_lane(input logic [63:0] x, input logic [1:0] mode);
        logic [63:0] y;
        int unsigned r;
        int unsigned c;
        int unsigned src;
        y = x;
        for (int unsigned i = 1; i <= 64; i++) begin
            r   = (i - 1) / 8;
            c   = (i - 1) % 8;
            src = i;
            if (mode == MODE_IP) begin
                src = ((r < 4) ? (58 + 2 * r) : (57 + 2 * (r - 4))) - 8 * c;
            end else if (mode == MODE_IP_INV) begin
                src = (((c % 2) == 0) ? 40 : 8) - r + 8 * (c / 2);
            end
            y[64 - i] = x[64 - src];
        end
        return y;
    endfunction

    always_comb begin
        perm_beat = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            perm_beat[64*l +: 64] = perm_lane(in_data[64*l +: 64], in_mode);
        end
    end

    // Unrolled ready chain: a stage is ready if it or any stage downstream is empty, or out_ready.
    always_comb begin
        rdy_acc = out_ready;
        rdy     = '0;
        for (int unsigned k = 0; k < PIPE; k++) begin
            rdy_acc           = rdy_acc || !v_q[PIPE-1-k];
            rdy[PIPE-1-k]     = rdy_acc;
        end
    end

    assign in_ready   = rdy[0];
    assign accept     = in_valid && rdy[0];
    assign out_valid  = v_q[PIPE-1];
    assign out_data   = data_q[PIPE-1];
    assign beat_count = count_q;
    assign mode_err   = mode_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q        <= '0;
            count_q    <= '0;
            mode_err_q <= 1'b0;
            for (int unsigned k = 0; k < PIPE; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            if (rdy[0]) begin
                v_q[0]    <= in_valid;
                data_q[0] <= perm_beat;
            end
            for (int unsigned k = 1; k < PIPE; k++) begin
                if (rdy[k]) begin
                    v_q[k]    <= v_q[k-1];
                    data_q[k] <= data_q[k-1];
                end
            end
            if (accept) begin
                count_q <= count_q + 32'd1;
            end
            if (accept && (in_mode == MODE_RSVD)) begin
                mode_err_q <= 1'b1;
            end else if (err_clr) begin
                mode_err_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_des_perm_stream.sv
// Directed/self-checking bench for des_perm_stream (LANES=4, PIPE=2) using
// table-driven DES IP / IP^-1 reference permutations.
module tb_des_perm_stream;

    localparam int unsigned LANES = 4;
    localparam int unsigned PIPE  = 2;
    localparam int unsigned W     = 64 * LANES;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };
    localparam int IPI_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_mode;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [31:0]   beat_count;
    logic          mode_err;
    logic          err_clr;

    int            checks;
    int            failures;
    logic [31:0]   exp_count;

    logic [1:0]    q_mode [$];
    logic [W-1:0]  q_data [$];
    logic [W-1:0]  q_exp  [$];

    des_perm_stream #(.LANES(LANES), .PIPE(PIPE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .beat_count (beat_count),
        .mode_err   (mode_err),
        .err_clr    (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_lane(input logic [63:0] x, input logic [1:0] m);
        logic [63:0] y;
        y = x;
        for (int i = 0; i < 64; i++) begin
            if (m == 2'b01) y[63 - i] = x[64 - IP_T[i]];
            else if (m == 2'b10) y[63 - i] = x[64 - IPI_T[i]];
        end
        return y;
    endfunction

    function automatic logic [W-1:0] ref_beat(input logic [W-1:0] x, input logic [1:0] m);
        logic [W-1:0] y;
        for (int l = 0; l < LANES; l++) y[64*l +: 64] = ref_lane(x[64*l +: 64], m);
        return y;
    endfunction

    function automatic logic [W-1:0] rand_beat();
        logic [W-1:0] y;
        for (int k = 0; k < W / 32; k++) y[32*k +: 32] = $urandom;
        return y;
    endfunction

    task automatic push_beat(input logic [1:0] m, input logic [W-1:0] d, input logic [W-1:0] e);
        q_mode.push_back(m);
        q_data.push_back(d);
        q_exp.push_back(e);
    endtask

    // Drives the queued beats with random valid/ready and checks order, stall stability and in_ready.
    task automatic run_stream(input string name, input int vpct, input int rpct, input int max_cycles);
        int          total;
        int          sent;
        int          recv;
        int          cyc;
        int          inflight;
        logic        exp_rdy;
        logic        stalled;
        logic [W-1:0] held;
        total   = q_mode.size();
        sent    = 0;
        recv    = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        while (recv < total && cyc < max_cycles) begin
            @(posedge clk); #1;
            if (sent < total && $urandom_range(99) < vpct) begin
                in_valid = 1'b1;
                in_mode  = q_mode[sent];
                in_data  = q_data[sent];
            end else begin
                in_valid = 1'b0;
                in_mode  = 2'($urandom_range(3));
                in_data  = rand_beat();
            end
            out_ready = ($urandom_range(99) < rpct);
            @(negedge clk);
            inflight = sent - recv;
            exp_rdy  = !(inflight == PIPE && !out_ready);
            checks++;
            if (in_ready !== exp_rdy) begin
                failures++;
                $display("FAIL %s in_ready: got %b expected %b (inflight %0d)", name, in_ready, exp_rdy, inflight);
            end
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    failures++;
                    $display("FAIL %s stall_hold: got v=%b %h expected v=1 %h", name, out_valid, out_data, held);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (recv >= total) begin
                    failures++;
                    $display("FAIL %s extra_beat: got %h expected no beat", name, out_data);
                end else begin
                    if (out_data !== q_exp[recv]) begin
                        failures++;
                        $display("FAIL %s data[%0d]: got %h expected %h", name, recv, out_data, q_exp[recv]);
                    end
                    recv++;
                end
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            if (in_valid && in_ready) begin
                sent++;
                exp_count = exp_count + 32'd1;
            end
            cyc++;
        end
        checks++;
        if (recv != total) begin
            failures++;
            $display("FAIL %s timeout: got %0d beats expected %0d", name, recv, total);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (beat_count !== exp_count) begin
            failures++;
            $display("FAIL %s beat_count: got %h expected %h", name, beat_count, exp_count);
        end
        q_mode.delete();
        q_data.delete();
        q_exp.delete();
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || beat_count !== 32'd0 || mode_err !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: got v=%b d=%h cnt=%h err=%b rdy=%b expected v=0 d=0 cnt=0 err=0 rdy=1",
                     out_valid, out_data, beat_count, mode_err, in_ready);
        end
    endtask

    task automatic test_known_vector(input string name, input logic [1:0] m, input logic [63:0] din, input logic [63:0] dexp);
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_mode   = m;
        in_data   = {192'h0, din};
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s accept: got in_ready=%b expected 1", name, in_ready);
        end
        exp_count = exp_count + 32'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s early_valid: got %b expected 0", name, out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== {192'h0, dexp} || beat_count !== exp_count) begin
            failures++;
            $display("FAIL %s result: got v=%b %h cnt=%h expected v=1 %h cnt=%h",
                     name, out_valid, out_data, beat_count, {192'h0, dexp}, exp_count);
        end
        @(negedge clk);
    endtask

    task automatic test_stream_alt();
        logic [W-1:0] x;
        logic [W-1:0] y;
        for (int k = 0; k < 100; k++) begin
            x = rand_beat();
            y = ref_beat(x, 2'b01);
            push_beat(2'b01, x, y);
            push_beat(2'b10, y, x);
        end
        run_stream("stream_alt", 100, 100, 1000);
    endtask

    task automatic test_walking();
        logic [W-1:0] one;
        logic [W-1:0] d;
        one = 1;
        for (int m = 1; m <= 2; m++) begin
            for (int p = 0; p < W; p++) begin
                d = one << p;
                push_beat(2'(m), d, ref_beat(d, 2'(m)));
            end
        end
        for (int k = 0; k < 8; k++) begin
            d = rand_beat();
            push_beat(2'b00, d, d);
        end
        run_stream("walking", 100, 100, 2000);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] d;
        logic [1:0]   m;
        for (int k = 0; k < 1000; k++) begin
            d = rand_beat();
            m = 2'($urandom_range(2));
            push_beat(m, d, ref_beat(d, m));
        end
        run_stream("backpressure", 70, 50, 20000);
        checks++;
        if (mode_err !== 1'b0) begin
            failures++;
            $display("FAIL bp_mode_err: got %b expected 0", mode_err);
        end
    endtask

    task automatic test_mode_err();
        logic [W-1:0] d;
        d = rand_beat();
        push_beat(2'b11, d, d);
        run_stream("mode11_pass", 100, 100, 100);
        checks++;
        if (mode_err !== 1'b1) begin
            failures++;
            $display("FAIL mode_err_set: got %b expected 1", mode_err);
        end
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_mode   = 2'b11;
        in_data   = rand_beat();
        err_clr   = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL clr_vs_set_accept: got in_ready=%b expected 1", in_ready);
        end
        exp_count = exp_count + 32'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        err_clr  = 1'b0;
        @(negedge clk);
        checks++;
        if (mode_err !== 1'b1) begin
            failures++;
            $display("FAIL clr_vs_set: got %b expected 1", mode_err);
        end
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(negedge clk);
        checks++;
        if (mode_err !== 1'b1) begin
            failures++;
            $display("FAIL clr_sync: got %b expected 1 before edge", mode_err);
        end
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (mode_err !== 1'b0 || beat_count !== exp_count) begin
            failures++;
            $display("FAIL clr_alone: got err=%b cnt=%h expected err=0 cnt=%h", mode_err, beat_count, exp_count);
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] d;
        @(negedge clk);
        dut.count_q = 32'hFFFF_FFFE;
        exp_count   = 32'hFFFF_FFFE;
        d = rand_beat();
        push_beat(2'b01, d, ref_beat(d, 2'b01));
        run_stream("wrap_to_max", 100, 100, 100);
        checks++;
        if (beat_count !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL wrap_max: got %h expected ffffffff", beat_count);
        end
        d = rand_beat();
        push_beat(2'b10, d, ref_beat(d, 2'b10));
        run_stream("wrap_to_zero", 100, 100, 100);
        checks++;
        if (beat_count !== 32'h0) begin
            failures++;
            $display("FAIL wrap_zero: got %h expected 00000000", beat_count);
        end
    endtask

    task automatic test_reset_inflight();
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'b01;
        in_data   = rand_beat();
        @(posedge clk); #1;
        in_data   = rand_beat();
        @(posedge clk); #1;
        in_valid  = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_pipe: got v=%b rdy=%b expected v=1 rdy=0", out_valid, in_ready);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || beat_count !== 32'd0 || mode_err !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got v=%b d=%h cnt=%h err=%b expected all 0",
                     out_valid, out_data, beat_count, mode_err);
        end
        exp_count = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset: got rdy=%b v=%b expected rdy=1 v=0", in_ready, out_valid);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        exp_count = 32'd0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 2'b00;
        in_data   = '0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_known_vector("ip_vector", 2'b01, 64'h0123456789ABCDEF, 64'hCC00CCFFF0AAF0AA);
        test_known_vector("ipinv_vector", 2'b10, 64'hCC00CCFFF0AAF0AA, 64'h0123456789ABCDEF);
        test_stream_alt();
        test_walking();
        test_backpressure();
        test_mode_err();
        test_wrap();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
